// File: rtl/fdiv_seq.sv
// fdiv_seq: sequential signed Q1.(n-1) restoring divider, one quotient bit per clock; FDIV_ROUND_EN enables round-to-nearest
module fdiv_seq #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result,
  output logic [3:0]   flags
);
  localparam int w = 2*n-1;
  localparam int cw = $clog2(w+1);
  localparam logic [n-1:0] maxp = {1'b0, {(n-1){1'b1}}};
  localparam logic [n-1:0] minn = {1'b1, {(n-1){1'b0}}};
  localparam logic [w:0] pmax = (w+1)'(2**(n-1)-1);
  localparam logic [w:0] nmax = (w+1)'(2**(n-1));
  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;
  state_t state;
  logic sa, sb, ge, sg, dz, povf, novf;
  logic [n-1:0] ab, aa, ba, rem, res;
  logic [n:0] rs;
  logic [w-1:0] quo, dvd;
  logic [w:0] mag;
  logic [cw-1:0] cnt;
  always_comb begin
    aa = a[n-1] ? -a : a;
    ba = b[n-1] ? -b : b;
    rs = {rem, dvd[w-1]};
    ge = rs >= {1'b0, ab};
`ifdef FDIV_ROUND_EN
    mag = {1'b0, quo} + {{w{1'b0}}, {rem, 1'b0} >= {1'b0, ab}};
`else
    mag = {1'b0, quo};
`endif
    sg = sa ^ sb;
    dz = ab == '0;
    povf = !sg && mag > pmax;
    novf = sg && mag > nmax;
    res = dz ? (sa ? minn : maxp) : povf ? maxp : novf ? minn : sg ? -mag[n-1:0] : mag[n-1:0];
  end
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      flags <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sa <= a[n-1];
          sb <= b[n-1];
          ab <= ba;
          rem <= '0;
          quo <= '0;
          dvd <= {aa, {(n-1){1'b0}}};
          cnt <= cw'(w);
          busy <= 1'b1;
          state <= b == '0 ? FIX : DIV;
        end
        DIV: begin
          rem <= n'(ge ? rs - {1'b0, ab} : rs);
          quo <= {quo[w-2:0], ge};
          dvd <= dvd << 1;
          cnt <= cnt - 1'b1;
          if (cnt == cw'(1)) state <= FIX;
        end
        FIX: begin
          result <= res;
          flags <= {dz | povf | novf, res[n-1], res == '0, dz};
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: scoreboard bench for fdiv_seq, directed cases from the plan plus randomized operands against an arithmetic model
module tb_fdiv_seq;
  localparam int n = 8;
  logic clk = 0, nreset = 0, start = 0;
  logic [n-1:0] a = 0, b = 0, result;
  logic busy, done;
  logic [3:0] flags;
  int checks = 0, errors = 0, cyc = 0, dones = 0, bcnt = 0;
  logic [n+3:0] eq[$];
  int tq[$];

  fdiv_seq #(.n(n)) dut (.clk(clk), .nreset(nreset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .flags(flags));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy) bcnt = bcnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Q1.(n-1) division as plain integer arithmetic, clamped to the signed range
  function automatic logic [n+3:0] model(input logic [n-1:0] x, input logic [n-1:0] y);
    int xi, yi, mx, my, q, rm, v;
    logic [n-1:0] r;
    logic ov, c;
    xi = int'($signed(x));
    yi = int'($signed(y));
    mx = xi < 0 ? -xi : xi;
    my = yi < 0 ? -yi : yi;
    c = 0;
    ov = 0;
    if (my == 0) begin
      v = xi < 0 ? -(2**(n-1)) : 2**(n-1)-1;
      ov = 1;
      c = 1;
    end else begin
      q = (mx * 2**(n-1)) / my;
      rm = (mx * 2**(n-1)) % my;
`ifdef FDIV_ROUND_EN
      if (2*rm >= my) q++;
`endif
      v = ((xi < 0) != (yi < 0)) ? -q : q;
      if (v > 2**(n-1)-1) begin v = 2**(n-1)-1; ov = 1; end
      if (v < -(2**(n-1))) begin v = -(2**(n-1)); ov = 1; end
    end
    r = n'(v);
    return {r, ov, r[n-1], r == 0, c};
  endfunction

  always @(negedge clk) if (done) begin
    dones++;
    if (eq.size() == 0) chk("unexpected_done", 1, 0);
    else begin
      chk("result_flags", {result, flags}, eq.pop_front());
      chk("latency", cyc, tq.pop_front());
    end
  end

  task automatic issue(input logic [n-1:0] x, input logic [n-1:0] y, input logic [n+3:0] ex, input bit track);
    a = x;
    b = y;
    start = 1;
    if (track) begin
      eq.push_back(ex);
      tq.push_back(cyc + 1 + (y == 0 ? 1 : 2*n));
    end
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (eq.size() == 0 && !busy && !done) return;
      @(negedge clk);
    end
    chk("timeout", 1, 0);
    eq.delete();
    tq.delete();
  endtask

  typedef struct { logic [7:0] x, y, r; logic [3:0] f; } vec_t;
  vec_t dir[$] = '{
    '{8'h20, 8'h40, 8'h40, 4'b0000}, '{8'hE0, 8'h40, 8'hC0, 4'b0100},
    '{8'hC0, 8'h40, 8'h80, 4'b0100}, '{8'h40, 8'h40, 8'h7F, 4'b1000},
    '{8'h7F, 8'h01, 8'h7F, 4'b1000}, '{8'h10, 8'h00, 8'h7F, 4'b1001},
    '{8'h90, 8'h00, 8'h80, 4'b1101},
`ifdef FDIV_ROUND_EN
    '{8'h01, 8'h03, 8'h2B, 4'b0000},
`else
    '{8'h01, 8'h03, 8'h2A, 4'b0000},
`endif
    '{8'h00, 8'h35, 8'h00, 4'b0010}};

  initial begin
    int d0;
    logic [n-1:0] rx, ry;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    nreset = 1;
    @(negedge clk);
    bcnt = 0;
    foreach (dir[i]) begin
      issue(dir[i].x, dir[i].y, {dir[i].r, dir[i].f}, 1);
      wait_idle();
      if (i == 0) chk("busy_cycles", bcnt, 2*n);
    end
    d0 = dones;
    issue(8'h30, 8'h40, {8'h60, 4'b0000}, 1);
    repeat (2) @(negedge clk);
    a = 8'h11;
    b = 8'h00;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_ignore", busy, 1);
    wait_idle();
    chk("one_done", dones - d0, 1);
    issue(8'h50, 8'h20, '0, 0);
    repeat (4) @(negedge clk);
    nreset = 0;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_result", result, 0);
    chk("mid_flags", flags, 0);
    nreset = 1;
    d0 = dones;
    repeat (25) @(negedge clk);
    chk("no_done_after_rst", dones, d0);
    issue(8'h20, 8'h40, {8'h40, 4'b0000}, 1);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    issue(8'hE0, 8'h40, {8'hC0, 4'b0100}, 1);
    wait_idle();
    for (int i = 0; i < 300; i++) begin
      rx = n'($urandom);
      ry = $urandom_range(0, 7) == 0 ? '0 : n'($urandom);
      issue(rx, ry, model(rx, ry), 1);
      if (i % 4 == 0) wait_idle();
      else begin
        for (int j = 0; j < 40 && !done; j++) @(negedge clk);
      end
    end
    wait_idle();
    chk("queue_empty", eq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
